// File: rtl/time_ctrl.sv
// Run/set controller for the HH:MM:SS counter chain: 1 Hz tick prescaler, start/stop/clear,
// and set-mode FSM issuing single-step increments. Optional blink logic under TIME_CTRL_BLINK_EN.
module time_ctrl #(
  parameter int unsigned PRESCALE    = 50000000,
  parameter int unsigned PRE_WIDTH   = 26,
  parameter int unsigned BLINK_DIV   = 12500000,
  parameter int unsigned BLINK_WIDTH = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_startstop,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clear,
  output logic       en_tick,
  output logic       clr_cnt,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic [1:0] field_sel,
  output logic       running,
  output logic       blink
);

  typedef enum logic [2:0] {StStop, StRun, StSetH, StSetM, StSetS} state_e;

  localparam logic [PRE_WIDTH-1:0] PreMax = PRE_WIDTH'(PRESCALE - 1);

  state_e               state_q, state_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic [3:0]           btn_now, btn_q, edges;
  logic                 act_clear, act_ss, act_mode, act_inc;
  logic                 en_tick_d, clr_cnt_d, inc_hour_d, inc_min_d, inc_sec_d;
  logic [1:0]           field_sel_d;

  assign btn_now = {btn_clear, btn_startstop, btn_mode, btn_inc};
  assign edges   = btn_now & ~btn_q;

  // One action per cycle; lower-priority edges in the same cycle are dropped.
  assign act_clear = edges[3];
  assign act_ss    = edges[2] & ~edges[3];
  assign act_mode  = edges[1] & ~edges[2] & ~edges[3];
  assign act_inc   = edges[0] & ~edges[1] & ~edges[2] & ~edges[3];

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    en_tick_d  = 1'b0;
    clr_cnt_d  = 1'b0;
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    inc_sec_d  = 1'b0;
    if (act_clear) begin
      clr_cnt_d = 1'b1;
      pre_d     = '0;
    end else begin
      unique case (state_q)
        StStop: begin
          if (act_ss) begin
            state_d = StRun;
          end else if (act_mode) begin
            state_d = StSetH;
            pre_d   = '0;
          end
        end
        StRun: begin
          if (act_ss) begin
            state_d = StStop;
          end else if (pre_q == PreMax) begin
            pre_d     = '0;
            en_tick_d = 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        StSetH, StSetM, StSetS: begin
          if (act_ss) begin
            state_d = StRun;
            pre_d   = '0;
          end else if (act_mode) begin
            state_d = (state_q == StSetH) ? StSetM :
                      (state_q == StSetM) ? StSetS : StStop;
          end else if (act_inc) begin
            inc_hour_d = (state_q == StSetH);
            inc_min_d  = (state_q == StSetM);
            inc_sec_d  = (state_q == StSetS);
          end
        end
        default: state_d = StStop;
      endcase
    end
  end

  always_comb begin
    field_sel_d = 2'd0;
    case (state_d)
      StSetH:  field_sel_d = 2'd1;
      StSetM:  field_sel_d = 2'd2;
      StSetS:  field_sel_d = 2'd3;
      default: field_sel_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StStop;
      pre_q     <= '0;
      btn_q     <= '0;
      en_tick   <= 1'b0;
      clr_cnt   <= 1'b0;
      inc_hour  <= 1'b0;
      inc_min   <= 1'b0;
      inc_sec   <= 1'b0;
      field_sel <= 2'd0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      btn_q     <= btn_now;
      en_tick   <= en_tick_d;
      clr_cnt   <= clr_cnt_d;
      inc_hour  <= inc_hour_d;
      inc_min   <= inc_min_d;
      inc_sec   <= inc_sec_d;
      field_sel <= field_sel_d;
      running   <= (state_d == StRun);
    end
  end

`ifdef TIME_CTRL_BLINK_EN
  localparam logic [BLINK_WIDTH-1:0] BlinkMax = BLINK_WIDTH'(BLINK_DIV - 1);

  logic [BLINK_WIDTH-1:0] bcnt_q, bcnt_d;
  logic                   blink_d;
  logic                   stay_set;

  // Counting only while remaining in the same SET state; any entry restarts the period.
  assign stay_set = (state_d == state_q) && (state_d inside {StSetH, StSetM, StSetS});

  always_comb begin
    bcnt_d  = '0;
    blink_d = 1'b1;
    if (stay_set) begin
      if (bcnt_q == BlinkMax) begin
        bcnt_d  = '0;
        blink_d = ~blink;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
        blink_d = blink;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
      blink  <= 1'b1;
    end else begin
      bcnt_q <= bcnt_d;
      blink  <= blink_d;
    end
  end
`else
  assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_time_ctrl.sv
// Directed table-driven bench for time_ctrl with PRESCALE=4, BLINK_DIV=3.
module tb_time_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_startstop, btn_mode, btn_inc, btn_clear;
  logic       en_tick, clr_cnt, inc_hour, inc_min, inc_sec, running, blink;
  logic [1:0] field_sel;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  time_ctrl #(
    .PRESCALE   (4),
    .PRE_WIDTH  (3),
    .BLINK_DIV  (3),
    .BLINK_WIDTH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_startstop(btn_startstop),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .btn_clear    (btn_clear),
    .en_tick      (en_tick),
    .clr_cnt      (clr_cnt),
    .inc_hour     (inc_hour),
    .inc_min      (inc_min),
    .inc_sec      (inc_sec),
    .field_sel    (field_sel),
    .running      (running),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  // {en_tick, clr_cnt, inc_hour, inc_min, inc_sec, field_sel[1:0], running}
  assign outs = {en_tick, clr_cnt, inc_hour, inc_min, inc_sec, field_sel, running};

  // Buttons {clear, startstop, mode, inc}
  localparam logic [3:0] B0 = 4'b0000, BI = 4'b0001, BM = 4'b0010, BS = 4'b0100, BC = 4'b1000;
  localparam logic [7:0] STP  = 8'h00, RUN  = 8'h01, TICK = 8'h81, CLRR = 8'h41;
  localparam logic [7:0] SETH = 8'h02, SETM = 8'h04, SETS = 8'h06;
  localparam logic [7:0] IH   = 8'h22, IM   = 8'h14, IS   = 8'h0E, CLRM = 8'h44;

  typedef struct packed {
    logic [3:0] btn;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] b, input logic [7:0] e);
    vec_t v;
    v.btn = b;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [3:0] b);
    {btn_clear, btn_startstop, btn_mode, btn_inc} = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [14:0] blink_exp;
  logic [14:0] blink_btn_mode;

  initial begin
    // Run/stop/restart with preserved prescaler phase
    add(BS, RUN);  add(B0, RUN);  add(B0, RUN);  add(B0, RUN);  add(B0, TICK);
    add(B0, RUN);  add(B0, RUN);  add(B0, RUN);  add(B0, TICK); add(B0, RUN);
    add(BS, STP);  add(B0, STP);  add(B0, STP);  add(B0, STP);
    add(BS, RUN);  add(B0, RUN);  add(B0, RUN);  add(B0, TICK); add(B0, RUN);
    add(BS, STP);  add(B0, STP);
    // Set-mode walk
    add(BM, SETH); add(B0, SETH); add(BI, IH);   add(B0, SETH); add(BI, IH);   add(B0, SETH);
    add(BM, SETM); add(B0, SETM); add(BI, IM);   add(B0, SETM);
    add(BM, SETS); add(B0, SETS); add(BI, IS);   add(B0, SETS);
    add(BM, STP);  add(B0, STP);  add(BI, STP);  add(B0, STP);
    // Simultaneous clear+startstop+inc in SET_M
    add(BM, SETH); add(B0, SETH); add(BM, SETM); add(B0, SETM);
    add(BC | BS | BI, CLRM); add(B0, SETM); add(BI, IM); add(B0, SETM);
    // SET_M -> RUN clears prescaler; clear on the wrap cycle suppresses the tick
    add(BS, RUN);  add(B0, RUN);  add(B0, RUN);  add(B0, RUN);  add(BC, CLRR);
    add(B0, RUN);  add(B0, RUN);  add(B0, RUN);  add(B0, TICK);
    add(BM | BI, RUN); add(B0, RUN); add(BS, STP); add(B0, STP);

    // Reset and idle
    rst = 1'b1;
    {btn_clear, btn_startstop, btn_mode, btn_inc} = B0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs), 32'(STP));
    check("reset_blink", 32'(blink), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(B0);
      check($sformatf("idle%0d", i), 32'({outs, blink}), 32'({STP, 1'b1}));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].btn);
      check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
    end

    // Blink: enter SET_H, then mode mid-period into SET_M (bit 0 = first sample)
    blink_btn_mode = 15'b000_1000_0000_0001;
`ifdef TIME_CTRL_BLINK_EN
    blink_exp = 15'b011_1001_1100_0111;
`else
    blink_exp = 15'h7fff;
`endif
    for (int i = 0; i < 15; i++) begin
      step(blink_btn_mode[i] ? BM : B0);
      check($sformatf("blink%0d", i), 32'(blink), 32'(blink_exp[i]));
    end
    check("blink_fsel", 32'(field_sel), 32'd2);
    step(BM);
    step(BM);
    check("blink_exit", 32'({field_sel, blink}), 32'({2'd3, 1'b1}));
    step(B0);
    step(BM);
    check("to_stop", 32'(outs), 32'(STP));

    // Startstop held through reset release: exactly one edge after reset
    btn_startstop = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("held_reset", 32'(outs), 32'(STP));
    rst = 1'b0;
    step(BS);
    check("held_edge", 32'(outs), 32'(RUN));
    for (int i = 0; i < 3; i++) begin
      step(BS);
      check($sformatf("held_run%0d", i), 32'(outs), 32'(RUN));
    end
    step(BS);
    check("held_tick", 32'(outs), 32'(TICK));
    step(B0);
    check("held_after", 32'(outs), 32'(RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_ctrl.md
Name: time_ctrl

Overview:
Run/set controller for the HH:MM:SS digit-counter chain of the digital clock. It divides clk down to the 1 Hz seconds-chain enable and sequences start/stop/clear. It also runs a set-mode FSM that issues single-step increment pulses to the hour, minute and second counter groups. It sits between the debounced pushbuttons and the cascaded counter instances and owns all of their enable and clear inputs.

Parameters:
PRESCALE, 50000000, clk cycles per en_tick pulse (>=2)
PRE_WIDTH, 26, prescaler width; must satisfy 2**PRE_WIDTH >= PRESCALE
BLINK_DIV, 12500000, clk cycles per blink half-period (used only with BLINK_EN)
BLINK_WIDTH, 24, blink counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
btn_startstop  in  1  debounced level, rising edge acts
btn_mode  in  1  debounced level, rising edge acts
btn_inc  in  1  debounced level, rising edge acts
btn_clear  in  1  debounced level, rising edge acts
en_tick  out  1  1-cycle enable into seconds-units counter
clr_cnt  out  1  1-cycle clear to all time counters
inc_hour  out  1  1-cycle increment to hour group
inc_min  out  1  1-cycle increment to minute group
inc_sec  out  1  1-cycle increment to second group
field_sel  out  2  0 none, 1 hour, 2 min, 3 sec
running  out  1  high while in RUN
blink  out  1  display blank control for selected field (1 = show)

Behaviour:
- Single clock, synchronous active-high reset. All outputs are registered.
- Reset values: state STOP; prescaler 0; edge registers 0. en_tick, clr_cnt, inc_* 0; field_sel 0; running 0; blink 1.
- Edge detect: edge_x = btn_x & ~btn_x_q. btn_x_q is registered every cycle, including during rst, where it loads 0. A button held high through reset release gives one edge on the first post-reset cycle.
- Only one edge is acted on per cycle. Priority: clear > startstop > mode > inc. Lower-priority simultaneous edges are discarded, not queued.
- Action latency: an edge sampled at clock edge N produces its pulse or state change visible after edge N. Pulses are exactly 1 cycle wide.
- FSM states: STOP, RUN, SET_H, SET_M, SET_S.
- STOP: startstop -> RUN, prescaler keeps its value. mode -> SET_H, prescaler cleared. inc ignored.
- RUN: startstop -> STOP, prescaler frozen. mode and inc ignored.
- SET_H: inc -> inc_hour pulse; mode -> SET_M.
- SET_M: inc -> inc_min pulse; mode -> SET_S.
- SET_S: inc -> inc_sec pulse; mode -> STOP.
- Any SET_* state: startstop -> RUN with prescaler cleared to 0.
- clear, any state: clr_cnt pulse and prescaler cleared to 0; state unchanged.
- Prescaler advances only in RUN. Counts 0..PRESCALE-1, then wraps to 0.
- en_tick is asserted for the cycle after the clock edge at which the prescaler wraps. From prescaler 0, the first tick arrives PRESCALE cycles after entering RUN.
- en_tick is never asserted outside RUN. A clear in RUN on the wrap cycle suppresses that tick.
- field_sel is registered with the state: SET_H=1, SET_M=2, SET_S=3, else 0. running = (state==RUN).
- Counter wrap-around (59->00, 23->00) belongs to the counter chain. The controller does no time arithmetic.

Optional Feature:
Macro TIME_CTRL_BLINK_EN.
- Defined: a blink counter runs only in SET_* states. blink toggles when the counter reaches BLINK_DIV-1, and the counter then wraps to 0.
- Each entry into a SET_* state, including SET_H->SET_M and SET_M->SET_S, clears the counter and forces blink=1.
- Outside SET_* states, blink=1 and the counter is held at 0.
- Not defined: no blink counter is synthesised; blink is constant 1.

Test Plan:
(PRESCALE=4, BLINK_DIV=3)
1. Hold rst 3 cycles, then release with all buttons low -> outputs at reset values; en_tick stays 0 for 20 cycles.
2. Pulse startstop -> running=1 on the next cycle; en_tick pulses every 4th cycle, first 4 cycles after entry. Pulse startstop again -> running=0, no further ticks. Restart -> ticks resume with the preserved prescaler phase.
3. From STOP: mode, inc, inc, mode, inc, mode, inc, mode, inc, 1 cycle each separated by low cycles -> field_sel 1, then 2, then 3, then 0. Exactly 2 inc_hour, 1 inc_min and 1 inc_sec pulses. The last inc in STOP produces no pulse.
4. In SET_M, rise clear, startstop and inc on the same cycle -> only a clr_cnt pulse; state stays SET_M; no inc_min pulse; running=0.
5. In RUN, with the prescaler at 3, rise clear -> clr_cnt=1 and en_tick=0 on the following cycle. The next tick comes 4 cycles later.
6. With TIME_CTRL_BLINK_EN: enter SET_H -> blink pattern 1,1,1,0,0,0,1… Pressing mode mid-period -> SET_M with blink=1 and the period restarted. Without the macro -> blink constantly 1.
